// File: rtl/alu_result_bcd.sv
// Serial double-dabble converter: 20-bit ALU result to six packed BCD digits.
// Optional 7-segment output under ALU_BCD_SEG7_EN.
module alu_result_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] in_bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] out_bcd,
  output logic        out_ovf,
  output logic        out_valid
`ifdef ALU_BCD_SEG7_EN
  ,
  output logic [41:0] seg_n
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [19:0] sr_q;
  logic [27:0] acc_q;
  logic [27:0] adj;
  logic [27:0] shifted;
  logic [23:0] bcd_q, bcd_d, bcd_n;
  logic        ovf_q, ovf_d, ovf_n;
  logic        valid_q, valid_d;
  logic        accept;
  logic        last;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign accept = in_valid & in_ready;
  assign last   = (state_q == SHIFT) && (cnt_q == 5'd19);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < 7; i++) begin
      adj[i*4 +: 4] = add3(acc_q[i*4 +: 4]);
    end
  end

  assign shifted = {adj[26:0], sr_q[19]};
  // A nonzero millions digit cannot be shown, so the display saturates.
  assign ovf_n   = |shifted[27:24];
  assign bcd_n   = ovf_n ? 24'h999999 : shifted[23:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      sr_q  <= in_bin;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      sr_q  <= {sr_q[18:0], 1'b0};
      acc_q <= shifted;
      cnt_q <= cnt_q + 5'd1;
    end
  end

  always_comb begin
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    valid_d = last;
    if (last) begin
      bcd_d = bcd_n;
      ovf_d = ovf_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign out_bcd   = bcd_q;
  assign out_ovf   = ovf_q;
  assign out_valid = valid_q;

`ifdef ALU_BCD_SEG7_EN
  logic [41:0] seg_q, seg_d, seg_new;
  logic        lead;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Blank while every more-significant digit is zero; units always shown.
  always_comb begin
    seg_new = '1;
    lead    = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      lead = lead & (bcd_n[i*4 +: 4] == 4'd0);
      seg_new[i*7 +: 7] = lead ? 7'b1111111 : seg7(bcd_n[i*4 +: 4]);
    end
    seg_new[6:0] = seg7(bcd_n[3:0]);
  end

  always_comb begin
    seg_d = seg_q;
    if (last) seg_d = seg_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_q <= 42'h3FF_FFFF_FFFF;
    else        seg_q <= seg_d;
  end

  assign seg_n = seg_q;
`endif

endmodule
